// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: word width, reset vector, redirect kinds and
// the redirect target computation used by the fetch unit.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BRANCH,
    RD_JUMP,
    RD_JR
  } redirect_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] redirect_target(
    input redirect_e       kind,
    input logic [XLEN-1:0] pc,
    input logic [15:0]     imm16,
    input logic [25:0]     imm26,
    input logic [XLEN-1:0] rs
  );
    logic [XLEN-1:0] pc4;
    pc4 = pc + 32'd4;
    case (kind)
      RD_JR:     return {rs[31:2], 2'b00};
      RD_JUMP:   return {pc4[31:28], imm26, 2'b00};
      RD_BRANCH: return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
      default:   return pc4;
    endcase
  endfunction

endpackage

// File: rtl/mips_ifu_prefetch_if.sv
// Fetch unit bus: instruction-memory request/response port and the
// decode-side instruction handshake.
interface mips_ifu_prefetch_if;
  import mips_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

endinterface

// File: rtl/mips_ifu_queue.sv
// Prefetch queue: registered FIFO of {pc, inst} with synchronous flush.
// Head outputs read as zero whenever the queue is empty.
module mips_ifu_queue
  import mips_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic [XLEN-1:0]           push_pc,
  input  logic [XLEN-1:0]           push_inst,
  input  logic                      pop,
  output logic                      head_valid,
  output logic [XLEN-1:0]           head_pc,
  output logic [XLEN-1:0]           head_inst,
  output logic [$clog2(QDEPTH):0]   count
);
  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem_q [QDEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign head_valid = (count != '0);
  assign do_push    = push && !flush && (count != CW'(QDEPTH));
  assign do_pop     = pop && !flush && head_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr] <= '{pc: push_pc, inst: push_inst};
  end

  assign head_pc   = head_valid ? mem_q[rd_ptr].pc   : '0;
  assign head_inst = head_valid ? mem_q[rd_ptr].inst : '0;

endmodule

// File: rtl/mips_ifu_prefetch.sv
// Prefetching instruction fetch unit: PC, outstanding/stale accounting,
// redirect target selection and the prefetch queue.
module mips_ifu_prefetch
  import mips_pkg::*;
#(
  parameter int unsigned     QDEPTH   = 4,
  parameter int unsigned     MAX_OUTS = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  mips_ifu_prefetch_if.master bus,
  input  logic                ctl_valid,
  input  logic                ctl_branch,
  input  logic                ctl_zf,
  input  logic                ctl_jump,
  input  logic                ctl_jr,
  input  logic [XLEN-1:0]     ctl_pc,
  input  logic [15:0]         ctl_imm16,
  input  logic [25:0]         ctl_imm26,
  input  logic [XLEN-1:0]     ctl_rs
);
  localparam int unsigned OW = $clog2(MAX_OUTS + 1);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [XLEN-1:0] fetch_pc, rsp_pc, target;
  logic [OW-1:0]   outs, outs_nxt, discard;
  logic [CW-1:0]   q_count;
  redirect_e       rd_kind;
  logic            redirect, accepted, responded, push, credit_ok;
  logic            q_valid;
  logic [XLEN-1:0] q_pc, q_inst;

  always_comb begin
    rd_kind = RD_NONE;
    if (ctl_valid) begin
      if (ctl_jr)                     rd_kind = RD_JR;
      else if (ctl_jump)              rd_kind = RD_JUMP;
      else if (ctl_branch && ctl_zf)  rd_kind = RD_BRANCH;
    end
  end

  assign redirect = (rd_kind != RD_NONE);
  assign target   = redirect_target(rd_kind, ctl_pc, ctl_imm16, ctl_imm26, ctl_rs);

  // Queue credit counts live (non-stale) requests so a push can never overflow.
  assign credit_ok = (32'(outs) < MAX_OUTS) &&
                     ((32'(q_count) + 32'(outs) - 32'(discard)) < QDEPTH);

  assign bus.imem_req_valid = reset && credit_ok;
  assign bus.imem_addr      = fetch_pc;

  assign accepted  = bus.imem_req_valid && bus.imem_req_ready;
  assign responded = bus.imem_rsp_valid;
  assign outs_nxt  = outs + OW'(accepted) - OW'(responded);
  assign push      = responded && !redirect && (discard == '0);

  // Response PC moves only with pushed words, so it stays on the target while stale words drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outs     <= '0;
      discard  <= '0;
    end else begin
      outs <= outs_nxt;
      if (redirect) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        discard  <= outs_nxt;
      end else begin
        if (accepted) fetch_pc <= fetch_pc + 32'd4;
        if (responded) begin
          if (discard != '0) discard <= discard - OW'(1);
          else               rsp_pc  <= rsp_pc + 32'd4;
        end
      end
    end
  end

  mips_ifu_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_pc    (rsp_pc),
    .push_inst  (bus.imem_rsp_data),
    .pop        (bus.inst_ready),
    .head_valid (q_valid),
    .head_pc    (q_pc),
    .head_inst  (q_inst),
    .count      (q_count)
  );

  assign bus.inst_valid = q_valid;
  assign bus.inst_pc    = q_pc;
  assign bus.inst       = q_inst;

endmodule

// File: tb/tb_mips_ifu_prefetch.sv
// Directed bench for mips_ifu_prefetch with an in-order variable-latency
// instruction memory model.
module tb_mips_ifu_prefetch;
  import mips_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ctl_valid, ctl_branch, ctl_zf, ctl_jump, ctl_jr;
  logic [31:0] ctl_pc, ctl_rs;
  logic [15:0] ctl_imm16;
  logic [25:0] ctl_imm26;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned lat = 1;
  int unsigned cyc = 0;
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];
  logic [31:0] exp_pc;
  int          waited;

  mips_ifu_prefetch_if bus();

  mips_ifu_prefetch #(
    .QDEPTH  (4),
    .MAX_OUTS(2),
    .RESET_PC(RPC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ctl_valid (ctl_valid),
    .ctl_branch(ctl_branch),
    .ctl_zf    (ctl_zf),
    .ctl_jump  (ctl_jump),
    .ctl_jr    (ctl_jr),
    .ctl_pc    (ctl_pc),
    .ctl_imm16 (ctl_imm16),
    .ctl_imm26 (ctl_imm26),
    .ctl_rs    (ctl_rs)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Memory: records accepted requests and answers each lat cycles later, in order.
  always @(negedge clk) begin
    if (!reset) begin
      pend_addr.delete();
      pend_due.delete();
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        pend_addr.push_back(bus.imem_addr);
        pend_due.push_back(cyc + lat);
      end
      if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic ctl_clear();
    ctl_valid = 1'b0; ctl_branch = 1'b0; ctl_zf = 1'b0; ctl_jump = 1'b0; ctl_jr = 1'b0;
    ctl_pc = '0; ctl_rs = '0; ctl_imm16 = '0; ctl_imm26 = '0;
  endtask

  task automatic stream_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, {31'b0, bus.inst_valid}, 32'd1);
      check({tag, "_pc"}, bus.inst_pc, exp_pc);
      check({tag, "_inst"}, bus.inst, mem_word(exp_pc));
      exp_pc += 32'd4;
      @(negedge clk);
    end
  endtask

  task automatic wait_valid(input int limit, output int k);
    k = 0;
    while (bus.inst_valid !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (bus.inst_valid !== 1'b1) check("wait_valid_timeout", {31'b0, bus.inst_valid}, 32'd1);
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    ctl_clear();

    repeat (2) @(negedge clk);
    check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("rst_addr", bus.imem_addr, RPC);
    check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst_inst", bus.inst, 32'd0);
    check("rst_inst_pc", bus.inst_pc, 32'd0);

    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("c0_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("c0_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    check("c1_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("c1_addr", bus.imem_addr, 32'h4);
    @(negedge clk);
    exp_pc = 32'h0;
    stream_check("stream", 6);

    // Backpressure: queue fills to four entries and fetch stops.
    bus.inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("bp_valid", {31'b0, bus.inst_valid}, 32'd1);
    check("bp_hold_pc", bus.inst_pc, exp_pc);
    check("bp_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("bp_addr", bus.imem_addr, exp_pc + 32'd16);
    bus.inst_ready = 1'b1;
    stream_check("bp_drain", 8);

    // Taken branch back to 0x0C.
    ctl_valid = 1'b1; ctl_branch = 1'b1; ctl_zf = 1'b1; ctl_pc = 32'h10; ctl_imm16 = 16'hFFFE;
    @(negedge clk);
    ctl_clear();
    check("br_addr", bus.imem_addr, 32'h0000_000C);
    check("br_flush", {31'b0, bus.inst_valid}, 32'd0);
    @(negedge clk);
    check("br_bubble", {31'b0, bus.inst_valid}, 32'd0);
    @(negedge clk);
    exp_pc = 32'h0000_000C;
    stream_check("br_target", 3);

    // Same branch not taken: stream continues undisturbed.
    ctl_valid = 1'b1; ctl_branch = 1'b1; ctl_zf = 1'b0; ctl_pc = 32'h10; ctl_imm16 = 16'hFFFE;
    stream_check("nt", 1);
    ctl_clear();
    stream_check("nt", 3);

    // Mid-burst reset with a partly filled queue.
    bus.inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("mr_pre_valid", {31'b0, bus.inst_valid}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mr_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("mr_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("mr_addr", bus.imem_addr, RPC);
    check("mr_inst_pc", bus.inst_pc, 32'd0);
    lat = 3;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("mr_restart_req", {31'b0, bus.imem_req_valid}, 32'd1);
    check("mr_restart_addr", bus.imem_addr, RPC);

    // Stale discard: 3-cycle memory, redirect with two requests outstanding.
    @(negedge clk);
    check("sd_c1_addr", bus.imem_addr, 32'h4);
    @(negedge clk);
    check("sd_c2_full", {31'b0, bus.imem_req_valid}, 32'd0);
    ctl_valid = 1'b1; ctl_jump = 1'b1; ctl_pc = 32'h0; ctl_imm26 = 26'h100;
    @(negedge clk);
    ctl_clear();
    check("sd_addr", bus.imem_addr, 32'h0000_0400);
    check("sd_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    wait_valid(20, waited);
    check("sd_latency", 32'(waited), 32'd5);
    check("sd_pc", bus.inst_pc, 32'h0000_0400);
    check("sd_inst", bus.inst, mem_word(32'h0000_0400));

    // Priority: jr wins over jump.
    ctl_valid = 1'b1; ctl_jump = 1'b1; ctl_jr = 1'b1;
    ctl_rs = 32'h0000_1003; ctl_pc = 32'hF000_0000; ctl_imm26 = 26'h40;
    @(negedge clk);
    ctl_clear();
    check("pr_jr_addr", bus.imem_addr, 32'h0000_1000);
    wait_valid(30, waited);
    check("pr_jr_pc", bus.inst_pc, 32'h0000_1000);

    ctl_valid = 1'b1; ctl_jump = 1'b1; ctl_pc = 32'hF000_0000; ctl_imm26 = 26'h40;
    @(negedge clk);
    ctl_clear();
    check("pr_j_addr", bus.imem_addr, 32'hF000_0100);
    wait_valid(30, waited);
    check("pr_j_pc", bus.inst_pc, 32'hF000_0100);
    check("pr_j_inst", bus.inst, mem_word(32'hF000_0100));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
